// File: rtl/rs_issue_scheduler_if.sv
// ============================================================================
// Module   : rs_issue_scheduler_if
// Brief    : Dispatch, completion-broadcast and issue signals of the RS scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rs_issue_scheduler_if #(
  parameter int RS_DEPTH = 16,
  parameter int PREG_W   = 6,
  parameter int NUM_FU   = 3
);
  localparam int IDX_W = $clog2(RS_DEPTH);

  logic                     flush;
  logic                     alloc_v_1;
  logic                     alloc_v_2;
  logic [1:0]               alloc_fu_1;
  logic [1:0]               alloc_fu_2;
  logic [PREG_W-1:0]        alloc_ps1_1;
  logic [PREG_W-1:0]        alloc_ps2_1;
  logic [PREG_W-1:0]        alloc_ps1_2;
  logic [PREG_W-1:0]        alloc_ps2_2;
  logic                     alloc_r1_1;
  logic                     alloc_r2_1;
  logic                     alloc_r1_2;
  logic                     alloc_r2_2;
  logic [IDX_W-1:0]         alloc_idx_1;
  logic [IDX_W-1:0]         alloc_idx_2;
  logic                     disp_stall;
  logic [IDX_W:0]           free_cnt;
  logic [NUM_FU-1:0]        cdb_v;
  logic [NUM_FU*PREG_W-1:0] cdb_tag;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU-1:0]        issue_v;
  logic [NUM_FU*IDX_W-1:0]  issue_idx;

  modport master (
    output flush, alloc_v_1, alloc_v_2, alloc_fu_1, alloc_fu_2,
           alloc_ps1_1, alloc_ps2_1, alloc_ps1_2, alloc_ps2_2,
           alloc_r1_1, alloc_r2_1, alloc_r1_2, alloc_r2_2,
           cdb_v, cdb_tag, fu_ready,
    input  alloc_idx_1, alloc_idx_2, disp_stall, free_cnt, issue_v, issue_idx
  );

  modport slave (
    input  flush, alloc_v_1, alloc_v_2, alloc_fu_1, alloc_fu_2,
           alloc_ps1_1, alloc_ps2_1, alloc_ps1_2, alloc_ps2_2,
           alloc_r1_1, alloc_r2_1, alloc_r1_2, alloc_r2_2,
           cdb_v, cdb_tag, fu_ready,
    output alloc_idx_1, alloc_idx_2, disp_stall, free_cnt, issue_v, issue_idx
  );
endinterface

`default_nettype wire

// File: rtl/rs_issue_scheduler.sv
// ============================================================================
// Module   : rs_issue_scheduler
// Brief    : 16-entry RS wakeup/select: CDB snooping, oldest-ready grant per FU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_issue_scheduler #(
  parameter int RS_DEPTH = 16,
  parameter int PREG_W   = 6,
  parameter int NUM_FU   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  rs_issue_scheduler_if.slave  bus
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int AGE_W = 8;
  localparam logic [AGE_W-1:0] C_AGE_MAX = '1;
  localparam logic [AGE_W-1:0] C_AGE_ONE = AGE_W'(1);
  localparam logic [IDX_W:0]   C_CNT_ONE = (IDX_W+1)'(1);
  localparam logic [1:0]       C_FU_ILLEGAL = 2'd3;

  logic [RS_DEPTH-1:0] valid_q, valid_d;
  logic [RS_DEPTH-1:0] rdy1_q, rdy1_d;
  logic [RS_DEPTH-1:0] rdy2_q, rdy2_d;
  logic [1:0]          fu_q   [RS_DEPTH];
  logic [1:0]          fu_d   [RS_DEPTH];
  logic [PREG_W-1:0]   tag1_q [RS_DEPTH];
  logic [PREG_W-1:0]   tag1_d [RS_DEPTH];
  logic [PREG_W-1:0]   tag2_q [RS_DEPTH];
  logic [PREG_W-1:0]   tag2_d [RS_DEPTH];
  logic [AGE_W-1:0]    age_q  [RS_DEPTH];
  logic [AGE_W-1:0]    age_d  [RS_DEPTH];

  logic [IDX_W-1:0]    w_idx1, w_idx2;
  logic [IDX_W:0]      w_free_cnt;
  logic                w_stall;
  logic                w_we1, w_we2;
  logic [NUM_FU-1:0]   w_win_v;
  logic [IDX_W-1:0]    w_win_idx [NUM_FU];

  // True when any completion port broadcasts this tag in the current cycle.
  function automatic logic tag_hit(
    input logic [PREG_W-1:0]        tag,
    input logic [NUM_FU-1:0]        v,
    input logic [NUM_FU*PREG_W-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (v[f] && (tags[f*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Free list: two lowest invalid entries plus population count.
  always_comb begin
    logic found1, found2;
    found1     = 1'b0;
    found2     = 1'b0;
    w_idx1     = '0;
    w_idx2     = '0;
    w_free_cnt = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!valid_q[i]) begin
        w_free_cnt = w_free_cnt + C_CNT_ONE;
        if (!found1) begin
          w_idx1 = IDX_W'(i);
          found1 = 1'b1;
        end else if (!found2) begin
          w_idx2 = IDX_W'(i);
          found2 = 1'b1;
        end
      end
    end
  end

  assign w_stall = (w_free_cnt < (IDX_W+1)'(2));
  assign w_we1   = bus.alloc_v_1 && !w_stall && (bus.alloc_fu_1 != C_FU_ILLEGAL);
  assign w_we2   = bus.alloc_v_2 && !w_stall && (bus.alloc_fu_2 != C_FU_ILLEGAL);

  // Oldest-ready select; strict '>' keeps the lowest index on equal age.
  always_comb begin
    logic [AGE_W-1:0] best_age;
    best_age = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      w_win_v[f]   = 1'b0;
      w_win_idx[f] = '0;
      best_age     = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (valid_q[i] && (fu_q[i] == 2'(f)) && rdy1_q[i] && rdy2_q[i] &&
            (!w_win_v[f] || (age_q[i] > best_age))) begin
          w_win_v[f]   = 1'b1;
          w_win_idx[f] = IDX_W'(i);
          best_age     = age_q[i];
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    fu_d    = fu_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    age_d   = age_q;

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (valid_q[i]) begin
        if (age_q[i] != C_AGE_MAX) age_d[i] = age_q[i] + C_AGE_ONE;
        if (tag_hit(tag1_q[i], bus.cdb_v, bus.cdb_tag)) rdy1_d[i] = 1'b1;
        if (tag_hit(tag2_q[i], bus.cdb_v, bus.cdb_tag)) rdy2_d[i] = 1'b1;
      end
    end

    for (int f = 0; f < NUM_FU; f++) begin
      if (w_win_v[f] && bus.fu_ready[f]) valid_d[w_win_idx[f]] = 1'b0;
    end

    // Nominated entries are currently invalid, so writes never collide with issue.
    if (w_we1) begin
      valid_d[w_idx1] = 1'b1;
      fu_d[w_idx1]    = bus.alloc_fu_1;
      tag1_d[w_idx1]  = bus.alloc_ps1_1;
      tag2_d[w_idx1]  = bus.alloc_ps2_1;
      rdy1_d[w_idx1]  = bus.alloc_r1_1 || (bus.alloc_ps1_1 == '0) ||
                        tag_hit(bus.alloc_ps1_1, bus.cdb_v, bus.cdb_tag);
      rdy2_d[w_idx1]  = bus.alloc_r2_1 || (bus.alloc_ps2_1 == '0) ||
                        tag_hit(bus.alloc_ps2_1, bus.cdb_v, bus.cdb_tag);
      age_d[w_idx1]   = '0;
    end
    if (w_we2) begin
      valid_d[w_idx2] = 1'b1;
      fu_d[w_idx2]    = bus.alloc_fu_2;
      tag1_d[w_idx2]  = bus.alloc_ps1_2;
      tag2_d[w_idx2]  = bus.alloc_ps2_2;
      rdy1_d[w_idx2]  = bus.alloc_r1_2 || (bus.alloc_ps1_2 == '0) ||
                        tag_hit(bus.alloc_ps1_2, bus.cdb_v, bus.cdb_tag);
      rdy2_d[w_idx2]  = bus.alloc_r2_2 || (bus.alloc_ps2_2 == '0) ||
                        tag_hit(bus.alloc_ps2_2, bus.cdb_v, bus.cdb_tag);
      age_d[w_idx2]   = '0;
    end

    if (bus.flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        fu_q[i]   <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      fu_q    <= fu_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      age_q   <= age_d;
    end
  end

  assign bus.alloc_idx_1 = w_idx1;
  assign bus.alloc_idx_2 = w_idx2;
  assign bus.free_cnt    = w_free_cnt;
  assign bus.disp_stall  = w_stall;
  assign bus.issue_v     = w_win_v;

  generate
    for (genvar f = 0; f < NUM_FU; f++) begin : g_issue_pack
      assign bus.issue_idx[f*IDX_W +: IDX_W] = w_win_idx[f];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rs_issue_scheduler.sv
// ============================================================================
// Module   : tb_rs_issue_scheduler
// Brief    : Directed self-checking bench for the RS wakeup/select scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_issue_scheduler;
  logic clk;
  logic rst;
  int   total;
  int   passed;

  rs_issue_scheduler_if bus_if ();

  rs_issue_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    bus_if.flush       = 1'b0;
    bus_if.alloc_v_1   = 1'b0;
    bus_if.alloc_v_2   = 1'b0;
    bus_if.alloc_fu_1  = 2'd0;
    bus_if.alloc_fu_2  = 2'd0;
    bus_if.alloc_ps1_1 = 6'd0;
    bus_if.alloc_ps2_1 = 6'd0;
    bus_if.alloc_ps1_2 = 6'd0;
    bus_if.alloc_ps2_2 = 6'd0;
    bus_if.alloc_r1_1  = 1'b0;
    bus_if.alloc_r2_1  = 1'b0;
    bus_if.alloc_r1_2  = 1'b0;
    bus_if.alloc_r2_2  = 1'b0;
    bus_if.cdb_v       = 3'b000;
    bus_if.cdb_tag     = 18'd0;
  endtask

  task automatic slot1(input logic [1:0] fu, input logic [5:0] t1, input logic r1,
                       input logic [5:0] t2, input logic r2);
    bus_if.alloc_v_1   = 1'b1;
    bus_if.alloc_fu_1  = fu;
    bus_if.alloc_ps1_1 = t1;
    bus_if.alloc_r1_1  = r1;
    bus_if.alloc_ps2_1 = t2;
    bus_if.alloc_r2_1  = r2;
  endtask

  task automatic slot2(input logic [1:0] fu, input logic [5:0] t1, input logic r1,
                       input logic [5:0] t2, input logic r2);
    bus_if.alloc_v_2   = 1'b1;
    bus_if.alloc_fu_2  = fu;
    bus_if.alloc_ps1_2 = t1;
    bus_if.alloc_r1_2  = r1;
    bus_if.alloc_ps2_2 = t2;
    bus_if.alloc_r2_2  = r2;
  endtask

  // Advance one edge; inputs are cleared afterwards and outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    idle_inputs();
    bus_if.fu_ready = 3'b111;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_free_cnt", 16'(bus_if.free_cnt), 16'd16);
    chk("rst_alloc_idx_1", 16'(bus_if.alloc_idx_1), 16'd0);
    chk("rst_alloc_idx_2", 16'(bus_if.alloc_idx_2), 16'd1);
    chk("rst_stall", 16'(bus_if.disp_stall), 16'd0);
    chk("rst_issue_v", 16'(bus_if.issue_v), 16'd0);
    chk("rst_issue_idx", 16'(bus_if.issue_idx), 16'd0);

    // Two ready dispatches issue the very next cycle.
    slot1(2'd0, 6'd3, 1'b1, 6'd4, 1'b1);
    slot2(2'd2, 6'd5, 1'b1, 6'd6, 1'b1);
    tick();
    chk("basic_issue_v", 16'(bus_if.issue_v), 16'b101);
    chk("basic_issue_idx", 16'(bus_if.issue_idx), 16'h100);
    chk("basic_free_cnt", 16'(bus_if.free_cnt), 16'd14);
    chk("basic_alloc_idx_1", 16'(bus_if.alloc_idx_1), 16'd2);
    tick();
    chk("basic_drain_free", 16'(bus_if.free_cnt), 16'd16);
    chk("basic_drain_v", 16'(bus_if.issue_v), 16'd0);

    // Wakeup through CDB port 0, two cycles after dispatch.
    slot1(2'd1, 6'd9, 1'b0, 6'd10, 1'b1);
    tick();
    chk("wake_wait1", 16'(bus_if.issue_v), 16'd0);
    tick();
    chk("wake_wait2", 16'(bus_if.issue_v), 16'd0);
    bus_if.cdb_v   = 3'b001;
    bus_if.cdb_tag = 18'd9;
    tick();
    chk("wake_issue_v", 16'(bus_if.issue_v), 16'b010);
    chk("wake_issue_idx", 16'(bus_if.issue_idx), 16'h000);
    tick();
    chk("wake_free", 16'(bus_if.free_cnt), 16'd16);

    // Same-cycle bypass from CDB port 2; tag 0 counts as ready.
    slot1(2'd1, 6'd9, 1'b0, 6'd0, 1'b0);
    bus_if.cdb_v   = 3'b100;
    bus_if.cdb_tag = {6'd9, 6'd0, 6'd0};
    tick();
    chk("bypass_issue_v", 16'(bus_if.issue_v), 16'b010);
    tick();
    chk("bypass_free", 16'(bus_if.free_cnt), 16'd16);

    // Non-matching tag must not wake; later match on port 1 does.
    slot1(2'd1, 6'd9, 1'b0, 6'd0, 1'b1);
    bus_if.cdb_v   = 3'b001;
    bus_if.cdb_tag = 18'd8;
    tick();
    chk("nomatch_issue_v", 16'(bus_if.issue_v), 16'd0);
    bus_if.cdb_v   = 3'b010;
    bus_if.cdb_tag = {6'd0, 6'd9, 6'd0};
    tick();
    chk("port1_issue_v", 16'(bus_if.issue_v), 16'b010);
    tick();
    chk("port1_free", 16'(bus_if.free_cnt), 16'd16);

    // Illegal FU in slot 1 is dropped; slot 2 still uses the second nomination.
    bus_if.fu_ready = 3'b000;
    slot1(2'd3, 6'd0, 1'b1, 6'd0, 1'b1);
    slot2(2'd0, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    chk("illegal_free", 16'(bus_if.free_cnt), 16'd15);
    chk("illegal_issue_idx", 16'(bus_if.issue_idx), 16'h001);
    bus_if.fu_ready = 3'b111;
    tick();
    chk("illegal_drain", 16'(bus_if.free_cnt), 16'd16);

    // Age ordering with FU0 held off.
    bus_if.fu_ready = 3'b000;
    slot1(2'd0, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    tick();
    slot1(2'd0, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    chk("age_first", 16'(bus_if.issue_idx), 16'h000);
    chk("age_first_v", 16'(bus_if.issue_v), 16'b001);
    tick();
    slot1(2'd0, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    chk("age_after_third", 16'(bus_if.issue_idx), 16'h000);
    chk("age_three_valid", 16'(bus_if.free_cnt), 16'd13);
    bus_if.fu_ready = 3'b111;
    tick();
    chk("age_order_1", 16'(bus_if.issue_idx), 16'h001);
    tick();
    chk("age_order_2", 16'(bus_if.issue_idx), 16'h002);
    tick();
    chk("age_done_v", 16'(bus_if.issue_v), 16'd0);
    chk("age_done_free", 16'(bus_if.free_cnt), 16'd16);

    // Backpressure on FU2 for five cycles.
    bus_if.fu_ready = 3'b000;
    slot1(2'd2, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_v", 16'(bus_if.issue_v), 16'b100);
      chk("bp_hold_free", 16'(bus_if.free_cnt), 16'd15);
      tick();
    end
    bus_if.fu_ready = 3'b100;
    tick();
    chk("bp_release_v", 16'(bus_if.issue_v), 16'd0);
    chk("bp_release_free", 16'(bus_if.free_cnt), 16'd16);

    // Fill every entry with unready FU0 work; entry i waits on tag 16+i.
    bus_if.fu_ready = 3'b111;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        chk("fill_free_2", 16'(bus_if.free_cnt), 16'd2);
        chk("fill_stall_2", 16'(bus_if.disp_stall), 16'd0);
      end
      slot1(2'd0, 6'(16 + 2*k), 1'b0, 6'd0, 1'b1);
      slot2(2'd0, 6'(17 + 2*k), 1'b0, 6'd0, 1'b1);
      tick();
    end
    chk("full_free", 16'(bus_if.free_cnt), 16'd0);
    chk("full_stall", 16'(bus_if.disp_stall), 16'd1);
    chk("full_issue_v", 16'(bus_if.issue_v), 16'd0);
    slot1(2'd0, 6'd0, 1'b1, 6'd0, 1'b1);
    slot2(2'd1, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    chk("full_ignored", 16'(bus_if.free_cnt), 16'd0);
    chk("full_ignored_v", 16'(bus_if.issue_v), 16'd0);
    bus_if.cdb_v   = 3'b001;
    bus_if.cdb_tag = 18'd21;
    tick();
    chk("full_wake_v", 16'(bus_if.issue_v), 16'b001);
    chk("full_wake_idx", 16'(bus_if.issue_idx), 16'h005);
    tick();
    chk("one_free_cnt", 16'(bus_if.free_cnt), 16'd1);
    chk("one_free_stall", 16'(bus_if.disp_stall), 16'd1);
    chk("one_free_idx", 16'(bus_if.alloc_idx_1), 16'd5);

    bus_if.flush = 1'b1;
    tick();
    chk("flush_full", 16'(bus_if.free_cnt), 16'd16);

    // Six valid entries, then flush racing allocation and a CDB hit.
    bus_if.fu_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      slot1(2'd0, 6'd40, 1'b0, 6'd0, 1'b1);
      slot2(2'd1, 6'd0, 1'b1, 6'd0, 1'b1);
      tick();
    end
    chk("pre_flush_free", 16'(bus_if.free_cnt), 16'd10);
    chk("pre_flush_v", 16'(bus_if.issue_v), 16'b010);
    bus_if.flush = 1'b1;
    slot1(2'd0, 6'd0, 1'b1, 6'd0, 1'b1);
    slot2(2'd2, 6'd0, 1'b1, 6'd0, 1'b1);
    bus_if.cdb_v   = 3'b001;
    bus_if.cdb_tag = 18'd40;
    tick();
    chk("flush_free", 16'(bus_if.free_cnt), 16'd16);
    chk("flush_issue_v", 16'(bus_if.issue_v), 16'd0);

    // Asynchronous reset between edges.
    slot1(2'd0, 6'd0, 1'b1, 6'd0, 1'b1);
    slot2(2'd2, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    chk("pre_rst_v", 16'(bus_if.issue_v), 16'b101);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_free", 16'(bus_if.free_cnt), 16'd16);
    chk("async_rst_v", 16'(bus_if.issue_v), 16'd0);
    chk("async_rst_idx2", 16'(bus_if.alloc_idx_2), 16'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
